sprite_compositor: RTL and testbench

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

---
 rtl/gfx_pkg.sv | 9 +
 rtl/sprite_compositor_if.sv | 12 +
 rtl/delay_line.sv | 24 ++
 rtl/sprite_compositor.sv | 93 +++++++++
 tb/tb_sprite_compositor.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/gfx_pkg.sv
// Shared graphics constants and the colour type used by the sprite pipeline.
package gfx_pkg;
  localparam int N_LAYERS = 3;
  localparam int ADDR_W   = 12;
  localparam int COLOR_W  = 24;
  typedef logic [COLOR_W-1:0] color_t;
  localparam color_t TRANSPARENT = 24'hFF00FF;
  localparam color_t BG_COLOR    = 24'h4EC0CA;
endpackage

// File: rtl/sprite_compositor_if.sv
// Sprite ROM bus: one registered address and one read-data word per layer.
interface sprite_compositor_if #(
  parameter int N_LAYERS = gfx_pkg::N_LAYERS,
  parameter int ADDR_W   = gfx_pkg::ADDR_W,
  parameter int COLOR_W  = gfx_pkg::COLOR_W
) ();
  logic [N_LAYERS-1:0][ADDR_W-1:0]  rom_addr;
  logic [N_LAYERS-1:0][COLOR_W-1:0] rom_data;

  modport master (output rom_addr, input  rom_data);
  modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/delay_line.sv
// Fixed-depth shift register with synchronous reset to a chosen value.
module delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= {DEPTH{RST_VAL}};
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/sprite_compositor.sv
// Three-stage sprite compositor: ROM address register, ROM read, then
// priority composite plus per-frame bird collision reporting.
module sprite_compositor #(
  parameter int                 N_LAYERS    = gfx_pkg::N_LAYERS,
  parameter int                 ADDR_W      = gfx_pkg::ADDR_W,
  parameter int                 COLOR_W     = gfx_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] TRANSPARENT = gfx_pkg::TRANSPARENT,
  parameter logic [COLOR_W-1:0] BG_COLOR    = gfx_pkg::BG_COLOR
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             active_in,
  input  logic                             hsync_in,
  input  logic                             vsync_in,
  input  logic [N_LAYERS-1:0]              in_bounds,
  input  logic [N_LAYERS-1:0][ADDR_W-1:0]  address,
  sprite_compositor_if.master              rom,
  output logic [COLOR_W-1:0]               rgb,
  output logic                             hsync_out,
  output logic                             vsync_out,
  output logic                             active_out,
  output logic                             collision,
  output logic                             collision_valid
);
  localparam int FW = N_LAYERS + 3;

  logic [FW-1:0]       flg_s3;
  logic [N_LAYERS-1:0] ib_s3, opaque;
  logic                act_s3, hs_s3, vs_s3;
  logic [COLOR_W-1:0]  rgb_n;
  logic                cand, frame_edge, pending;

  // Flags ride two stages so they meet the ROM data at composite time;
  // syncs park inactive (high) under reset.
  delay_line #(
    .WIDTH  (FW),
    .DEPTH  (2),
    .RST_VAL({{N_LAYERS{1'b0}}, 3'b011})
  ) u_flags (
    .clk (clk),
    .rst (rst),
    .d   ({in_bounds, active_in, hsync_in, vsync_in}),
    .q   (flg_s3)
  );

  assign {ib_s3, act_s3, hs_s3, vs_s3} = flg_s3;

  always_ff @(posedge clk) begin
    if (rst) rom.rom_addr <= '0;
    else     rom.rom_addr <= address;
  end

  for (genvar i = 0; i < N_LAYERS; i++) begin : g_lane
    assign opaque[i] = ib_s3[i] && (rom.rom_data[i] != TRANSPARENT);
  end

  // Walk from lowest priority up so the lowest-index opaque layer wins.
  always_comb begin
    rgb_n = BG_COLOR;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) rgb_n = rom.rom_data[i];
    end
    if (!act_s3) rgb_n = '0;
  end

  assign cand       = act_s3 & opaque[0] & (|opaque[N_LAYERS-1:1]);
  assign frame_edge = vsync_out & ~vs_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb             <= '0;
      hsync_out       <= 1'b1;
      vsync_out       <= 1'b1;
      active_out      <= 1'b0;
      collision       <= 1'b0;
      collision_valid <= 1'b0;
      pending         <= 1'b0;
    end else begin
      rgb             <= rgb_n;
      hsync_out       <= hs_s3;
      vsync_out       <= vs_s3;
      active_out      <= act_s3;
      collision_valid <= frame_edge;
      // A candidate on the edge cycle closes out with the old frame.
      if (frame_edge) begin
        collision <= pending | cand;
        pending   <= 1'b0;
      end else begin
        pending   <= pending | cand;
      end
    end
  end
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed + random bench for sprite_compositor with a 3-deep expected queue.
module tb_sprite_compositor;
  import gfx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                            rst = 1'b1;
  logic                            active_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [N_LAYERS-1:0]             in_bounds = '0;
  logic [N_LAYERS-1:0][ADDR_W-1:0] address = '0;
  color_t                          rgb;
  logic                            hsync_out, vsync_out, active_out, collision, collision_valid;

  sprite_compositor_if #(.N_LAYERS(N_LAYERS), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) rom_if ();

  sprite_compositor dut (
    .clk             (clk),
    .rst             (rst),
    .active_in       (active_in),
    .hsync_in        (hsync_in),
    .vsync_in        (vsync_in),
    .in_bounds       (in_bounds),
    .address         (address),
    .rom             (rom_if),
    .rgb             (rgb),
    .hsync_out       (hsync_out),
    .vsync_out       (vsync_out),
    .active_out      (active_out),
    .collision       (collision),
    .collision_valid (collision_valid)
  );

  // ROM contents depend only on the low 3 address bits.
  color_t pal [8] = '{24'hFF00FF, 24'hFFD700, 24'h00A000, 24'h123456,
                      24'hABCDEF, 24'hFF00FF, 24'h0000FF, 24'h777777};

  always @(posedge clk)
    for (int i = 0; i < N_LAYERS; i++) rom_if.rom_data[i] <= pal[rom_if.rom_addr[i][2:0]];

  typedef struct packed {
    color_t rgb;
    logic   hs, vs, act, coll, cval;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0, n_err = 0;
  logic m_pend = 1'b0, m_coll = 1'b0, m_prev_vs = 1'b1;
  logic [N_LAYERS-1:0][ADDR_W-1:0] last_addr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push();
    exp_t e;
    logic [2:0] op;
    logic cand, edge_;
    for (int i = 0; i < 3; i++) op[i] = in_bounds[i] && (pal[address[i][2:0]] !== TRANSPARENT);
    if (!active_in)  e.rgb = '0;
    else if (op[0])  e.rgb = pal[address[0][2:0]];
    else if (op[1])  e.rgb = pal[address[1][2:0]];
    else if (op[2])  e.rgb = pal[address[2][2:0]];
    else             e.rgb = BG_COLOR;
    cand  = active_in & op[0] & (op[1] | op[2]);
    edge_ = m_prev_vs & ~vsync_in;
    m_prev_vs = vsync_in;
    if (edge_) begin
      m_coll = m_pend | cand;
      m_pend = 1'b0;
    end else begin
      m_pend = m_pend | cand;
    end
    e.cval = edge_;
    e.coll = m_coll;
    e.hs   = hsync_in;
    e.vs   = vsync_in;
    e.act  = active_in;
    q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e, o;
    if (q.size() >= 3) begin
      e = q.pop_front();
      o = {rgb, hsync_out, vsync_out, active_out, collision, collision_valid};
      n_vec++;
      assert (o === e) else begin
        n_err++;
        $error("FAIL pixel got rgb=%h hs=%b vs=%b act=%b col=%b cv=%b exp rgb=%h hs=%b vs=%b act=%b col=%b cv=%b",
               o.rgb, o.hs, o.vs, o.act, o.coll, o.cval, e.rgb, e.hs, e.vs, e.act, e.coll, e.cval);
      end
    end
    chk("rom_addr", 64'(rom_if.rom_addr), 64'(last_addr));
  endtask

  task automatic step(input int act, input int hs, input int vs, input int ib,
                      input int a0, input int a1, input int a2);
    @(negedge clk);
    check_out();
    active_in  = (act != 0);
    hsync_in   = (hs != 0);
    vsync_in   = (vs != 0);
    in_bounds  = N_LAYERS'(ib);
    address[0] = ADDR_W'(a0);
    address[1] = ADDR_W'(a1);
    address[2] = ADDR_W'(a2);
    last_addr  = address;
    push();
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_out();
    rst = 1'b1;
    q.delete();
    repeat (2) @(negedge clk);
    chk("rst_rgb",  64'(rgb), 64'h0);
    chk("rst_hs",   64'(hsync_out), 64'h1);
    chk("rst_vs",   64'(vsync_out), 64'h1);
    chk("rst_act",  64'(active_out), 64'h0);
    chk("rst_col",  64'(collision), 64'h0);
    chk("rst_cv",   64'(collision_valid), 64'h0);
    chk("rst_addr", 64'(rom_if.rom_addr), 64'h0);
    rst = 1'b0;
    active_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    in_bounds = '0; address = '0; last_addr = '0;
    m_pend = 1'b0; m_coll = 1'b0; m_prev_vs = 1'b1;
    push();
  endtask

  initial begin
    do_reset();
    // Priority, transparency and blanking
    step(1, 1, 1, 3'b001, 1, 0, 0);
    step(1, 1, 1, 3'b011, 0, 2, 0);
    step(1, 1, 1, 3'b000, 1, 2, 3);
    step(1, 1, 1, 3'b011, 0, 0, 0);
    step(1, 1, 1, 3'b100, 0, 0, 3);
    step(0, 0, 1, 3'b111, 1, 2, 3);
    step(0, 1, 0, 3'b000, 0, 0, 0);
    step(0, 1, 0, 3'b000, 0, 0, 0);
    step(1, 1, 1, 3'b110, 0, 4, 6);
    // Bird over layer 2 mid-frame, then frame edge
    step(1, 1, 1, 3'b101, 1, 0, 3);
    step(1, 1, 1, 3'b010, 0, 2, 0);
    step(0, 1, 0, 3'b000, 0, 0, 0);
    repeat (4) step(0, 1, 1, 3'b000, 0, 0, 0);
    chk("col_hit_frame", 64'(collision), 64'h1);
    step(0, 1, 0, 3'b000, 0, 0, 0);
    repeat (4) step(0, 1, 1, 3'b000, 0, 0, 0);
    chk("col_clean_frame", 64'(collision), 64'h0);
    // Candidate coincident with the vsync edge
    step(1, 1, 0, 3'b101, 1, 0, 3);
    repeat (4) step(1, 1, 1, 3'b001, 1, 0, 0);
    chk("col_edge_coinc", 64'(collision), 64'h1);
    step(0, 1, 0, 3'b000, 0, 0, 0);
    repeat (4) step(0, 1, 1, 3'b000, 0, 0, 0);
    chk("col_after_coinc", 64'(collision), 64'h0);
    // Reset mid-frame after a candidate
    step(1, 1, 1, 3'b101, 1, 0, 3);
    step(1, 1, 1, 3'b001, 1, 0, 0);
    do_reset();
    repeat (2) step(0, 1, 1, 3'b000, 0, 0, 0);
    step(0, 1, 0, 3'b000, 0, 0, 0);
    repeat (4) step(0, 1, 1, 3'b000, 0, 0, 0);
    chk("col_after_rst", 64'(collision), 64'h0);
    // Random traffic
    repeat (80)
      step(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
           int'($urandom_range(0, 4095)));
    repeat (3) step(0, 1, 1, 3'b000, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
